// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_ONES_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with a synchronous clear and a combinational carry.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t max = 4'd9
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output bcd_t value,
  output logic carry_out
);

  bcd_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      // >= keeps the digit inside its range even from a corrupted state
      value_d = (value_q >= max) ? '0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value     = value_q;
  assign carry_out = inc & (value_q == max);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch counting synchronised 1 Hz tick edges.
// Optional lap/hold display enabled by macro STOPWATCH_LAP_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_q;
  logic                   tick_edge;
  sw_state_e              state_q, state_d;
  logic                   running_q;
  logic                   rollover_q;
  logic                   count_en;
  bcd_t                   so_v, st_v, mo_v, mt_v;
  logic                   c_so, c_st, c_mo, c_mt;
  logic [15:0]            live, disp;

  // The edge pulse is registered once more so digits move SYNC_STAGES+1
  // clocks after tick_in is first sampled high.
  assign tick_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      tick_q <= tick_edge;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_en = tick_q & (state_q == RUNNING) & ~clear;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= (state_d == RUNNING);
      rollover_q <= c_mt;
    end
  end

  bcd_digit #(.max(SEC_ONES_MAX)) u_sec_ones (
    .clock(clock), .reset_n(reset_n), .clr(clear), .inc(count_en),
    .value(so_v), .carry_out(c_so)
  );
  bcd_digit #(.max(SEC_TENS_MAX)) u_sec_tens (
    .clock(clock), .reset_n(reset_n), .clr(clear), .inc(c_so),
    .value(st_v), .carry_out(c_st)
  );
  bcd_digit #(.max(MIN_ONES_MAX)) u_min_ones (
    .clock(clock), .reset_n(reset_n), .clr(clear), .inc(c_st),
    .value(mo_v), .carry_out(c_mo)
  );
  bcd_digit #(.max(bcd_t'(MIN_TENS_MAX))) u_min_tens (
    .clock(clock), .reset_n(reset_n), .clr(clear), .inc(c_mo),
    .value(mt_v), .carry_out(c_mt)
  );

  assign live = {mt_v, mo_v, st_v, so_v};

`ifdef STOPWATCH_LAP_EN
  logic        hold_q, hold_d;
  logic [15:0] snap_q, snap_d;

  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (lap) begin
      hold_d = ~hold_q;
      if (!hold_q) snap_d = live;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign disp = hold_q ? snap_q : live;
`else
  assign disp = live;
`endif

  assign sec_ones = disp[3:0];
  assign sec_tens = disp[7:4];
  assign min_ones = disp[11:8];
  assign min_tens = disp[15:12];
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench: seconds-count reference model driven by random tick timing.
module tb_stopwatch_counter;

  localparam int SS     = 2;
  localparam int MTM    = 5;
  localparam int PERIOD = (MTM + 1) * 600;

  logic clock, reset_n, tick_in, start_stop, clear, lap;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic running, rollover;
  logic [15:0] dig;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;

  // reference model state
  int unsigned secs_m, snap_m;
  int          mode_m;          // 0 idle, 1 running, 2 paused
  bit          running_m, roll_m, hold_m;
  logic [7:0]  hist_m;          // hist_m[j] = tick_in sampled j+1 edges ago

  stopwatch_counter #(.SYNC_STAGES(SS), .MIN_TENS_MAX(MTM)) dut (
    .clock(clock), .reset_n(reset_n), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap),
`endif
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .rollover(rollover)
  );

  assign dig = {min_tens, min_ones, sec_tens, sec_ones};
  assign obs = {dig, running, rollover};

  initial clock = 1'b0;
  always #10 clock = ~clock;

  function automatic logic [15:0] to_bcd(input int unsigned s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10)};
  endfunction

  function automatic logic [17:0] expv();
    return {to_bcd(hold_m ? snap_m : secs_m), running_m, roll_m};
  endfunction

  task automatic step(input bit rst, input bit ss, input bit clr, input bit lp, input bit tk);
    bit pulse;
    @(negedge clock);
    reset_n = ~rst; start_stop = ss; clear = clr; lap = lp; tick_in = tk;
    @(posedge clock);
    if (rst) begin
      mode_m = 0; secs_m = 0; snap_m = 0; hold_m = 0;
      roll_m = 0; running_m = 0; hist_m = '0;
    end else begin
      pulse  = hist_m[SS] & ~hist_m[SS+1];
      roll_m = 0;
      if (clr) begin
        mode_m = 0; secs_m = 0; hold_m = 0;
      end else begin
`ifdef STOPWATCH_LAP_EN
        if (lp) begin
          if (!hold_m) begin snap_m = secs_m; hold_m = 1; end
          else hold_m = 0;
        end
`endif
        if (mode_m == 1 && pulse) begin
          if (secs_m == PERIOD - 1) begin secs_m = 0; roll_m = 1; end
          else secs_m = secs_m + 1;
        end
        if (ss) mode_m = (mode_m == 1) ? 2 : 1;
      end
      running_m = (mode_m == 1);
      hist_m = {hist_m[6:0], tk};
    end
    #1;
  endtask

  task automatic run_tick(input int h, input int l);
    for (int i = 0; i < h; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < l; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, i[0]);
      checks++;
      if (obs !== 18'h0) begin errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, 18'h0); end
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, (i % 3) != 2);
      checks++;
      if (obs !== expv() || obs !== 18'h0) begin
        errors++; $display("FAIL reset_release obs=%h exp=%h", obs, expv());
      end
    end
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_tick(2, 3);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL pre_reset_count obs=%h exp=%h", obs, expv()); end
    step(1, 1, 0, 0, 1);
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL reset_midcount obs=%h exp=%h", obs, 18'h0); end
  endtask

  task automatic test_count();
    logic [15:0] prev;
    int lat, h;
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int t = 0; t < 75; t++) begin
      prev = dig;
      lat  = -1;
      h    = $urandom_range(1, 3);
      for (int j = 0; j < h + 3; j++) begin
        step(0, 0, 0, 0, j < h);
        if (lat < 0 && dig !== prev) lat = j;
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL count t=%0d obs=%h exp=%h", t, obs, expv()); end
      end
      checks++;
      if (lat != SS + 1) begin errors++; $display("FAIL latency t=%0d got=%0d exp=%0d", t, lat, SS + 1); end
    end
    checks++;
    if (obs !== {16'h0115, 1'b1, 1'b0}) begin
      errors++; $display("FAIL count_75 obs=%h exp=%h", obs, {16'h0115, 1'b1, 1'b0});
    end
  endtask

  task automatic test_rollover();
    int rolls;
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int t = 0; t < PERIOD - 2; t++) begin
      run_tick(1, 1);
      checks++;
      if (obs !== expv() || sec_ones > 9 || sec_tens > 5 || min_ones > 9 || min_tens > MTM) begin
        errors++; $display("FAIL preload t=%0d obs=%h exp=%h", t, obs, expv());
      end
    end
    run_tick(0, 3);
    checks++;
    if (dig !== 16'h5958) begin errors++; $display("FAIL preload_5958 got=%h exp=5958", dig); end
    rolls = 0;
    for (int t = 0; t < 2; t++) begin
      for (int j = 0; j < 5; j++) begin
        step(0, 0, 0, 0, j == 0);
        rolls += rollover;
        checks++;
        if (obs !== expv() || min_tens > MTM) begin
          errors++; $display("FAIL wrap t=%0d j=%0d obs=%h exp=%h", t, j, obs, expv());
        end
      end
      checks++;
      if (dig !== (t == 0 ? 16'h5959 : 16'h0000)) begin
        errors++; $display("FAIL wrap_digits t=%0d got=%h", t, dig);
      end
    end
    checks++;
    if (rolls != 1 || running !== 1'b1) begin
      errors++; $display("FAIL rollover_once rolls=%0d running=%b exp 1/1", rolls, running);
    end
  endtask

  task automatic test_pause();
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int t = 0; t < 10; t++) run_tick(1, 3);
    step(0, 0, 0, 0, 1);
    for (int j = 0; j < SS; j++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    checks++;
    if (obs !== {16'h0011, 1'b0, 1'b0} || obs !== expv()) begin
      errors++; $display("FAIL ss_with_tick obs=%h exp=%h", obs, {16'h0011, 1'b0, 1'b0});
    end
    for (int t = 0; t < 5; t++) run_tick($urandom_range(1, 3), 3);
    checks++;
    if (obs !== {16'h0011, 1'b0, 1'b0}) begin
      errors++; $display("FAIL paused_hold obs=%h exp=%h", obs, {16'h0011, 1'b0, 1'b0});
    end
    step(0, 1, 0, 0, 0);
    for (int t = 0; t < 3; t++) run_tick(2, 2);
    checks++;
    if (obs !== {16'h0014, 1'b1, 1'b0} || obs !== expv()) begin
      errors++; $display("FAIL resume obs=%h exp=%h", obs, {16'h0014, 1'b1, 1'b0});
    end
  endtask

  task automatic test_clear_collision();
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int t = 0; t < 207; t++) run_tick(1, 1);
    run_tick(0, 2);
    checks++;
    if (dig !== 16'h0327) begin errors++; $display("FAIL reach_0327 got=%h exp=0327", dig); end
    step(0, 0, 0, 0, 1);
    for (int j = 0; j < SS; j++) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    checks++;
    if (obs !== 18'h0 || obs !== expv()) begin
      errors++; $display("FAIL clear_wins obs=%h exp=%h", obs, 18'h0);
    end
    run_tick(1, 3);
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL idle_after_clear obs=%h exp=%h", obs, 18'h0); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int t = 0; t < 5; t++) run_tick(1, 3);
    step(0, 0, 0, 1, 0);
    for (int t = 0; t < 4; t++) run_tick(2, 3);
    checks++;
    if (dig !== 16'h0005 || obs !== expv()) begin errors++; $display("FAIL lap_hold got=%h exp=0005", dig); end
    step(0, 0, 0, 1, 0);
    checks++;
    if (dig !== 16'h0009 || obs !== expv()) begin errors++; $display("FAIL lap_release got=%h exp=0009", dig); end
    step(0, 0, 0, 1, 0);
    run_tick(1, 3);
    step(0, 0, 1, 0, 0);
    checks++;
    if (dig !== 16'h0000 || obs !== expv()) begin errors++; $display("FAIL lap_clear got=%h exp=0000", dig); end
    step(0, 1, 0, 0, 0);
    run_tick(1, 3);
    checks++;
    if (dig !== 16'h0001 || obs !== expv()) begin errors++; $display("FAIL lap_live got=%h exp=0001", dig); end
  endtask
`endif

  task automatic test_random();
    bit rst, ss, clr, lp, tk;
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      ss  = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 63) == 0);
      lp  = ($urandom_range(0, 31) == 0);
      tk  = $urandom_range(0, 1);
      step(rst, ss, clr, lp, tk);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random i=%0d obs=%h exp=%h", i, obs, expv()); end
    end
  endtask

  initial begin
    reset_n = 1'b0; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    mode_m = 0; secs_m = 0; snap_m = 0; hold_m = 0; roll_m = 0; running_m = 0; hist_m = '0;
    test_reset();
    test_count();
    test_rollover();
    test_pause();
    test_clear_collision();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
